// File: rtl/volume_stepper_pkg.sv
// Shared constants and types for the volume UI: level width, repeat FSM encoding
// and default timing so display and other UI blocks agree on the same values.
package volume_stepper_pkg;

  localparam int unsigned LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 4'd15;

  // 100 MHz system clock defaults.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;
  localparam int unsigned DEF_LEVEL           = 8;

  typedef enum logic [1:0] {
    RptIdle,
    RptHold,
    RptRepeat
  } rpt_state_e;

  // Saturation is checked before the arithmetic so the 4-bit value never wraps.
  function automatic logic [LEVEL_W-1:0] sat_step(input logic [LEVEL_W-1:0] lvl,
                                                  input logic              up);
    logic [LEVEL_W-1:0] res;
    res = lvl;
    if (up) begin
      if (lvl != MAX_LEVEL) res = lvl + 1'b1;
    end else begin
      if (lvl != '0) res = lvl - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, consecutive-cycle debounce counter and a registered
// one-cycle press pulse on the rising edge of the debounced level.
module button_debouncer
  import volume_stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/volume_stepper.sv
// Volume level control from up/down/mute buttons: debounce, hold-to-repeat,
// saturating 4-bit level, mute with level memory and a change pulse.
module volume_stepper
  import volume_stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned DEFAULT_LEVEL   = DEF_LEVEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_mute,
  output logic [LEVEL_W-1:0] volume_level,
  output logic               muted,
  output logic               level_changed
);

  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [LEVEL_W-1:0] RST_LEVEL = LEVEL_W'(DEFAULT_LEVEL);

  // Index 0 is the up channel, index 1 the down channel.
  logic [1:0] rpt_level, rpt_press, step;
  logic       mute_level, mute_press;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up),
    .level (rpt_level[0]),
    .press (rpt_press[0])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down),
    .level (rpt_level[1]),
    .press (rpt_press[1])
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mute (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mute),
    .level (mute_level),
    .press (mute_press)
  );

  rpt_state_e       rpt_state_q [2];
  rpt_state_e       rpt_state_d [2];
  logic [CNT_W-1:0] rpt_cnt_q   [2];
  logic [CNT_W-1:0] rpt_cnt_d   [2];

  // Step requests are decoded from the registered state so the level register
  // updates on the cycle right after the debounced press edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      step[i]        = 1'b0;
      unique case (rpt_state_q[i])
        RptIdle: begin
          if (rpt_press[i]) begin
            step[i]        = 1'b1;
            rpt_state_d[i] = RptHold;
            rpt_cnt_d[i]   = '0;
          end
        end
        RptHold: begin
          if (!rpt_level[i]) begin
            rpt_state_d[i] = RptIdle;
          end else if (rpt_cnt_q[i] == CNT_W'(HOLD_CYCLES - 1)) begin
            step[i]        = 1'b1;
            rpt_state_d[i] = RptRepeat;
            rpt_cnt_d[i]   = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        RptRepeat: begin
          if (!rpt_level[i]) begin
            rpt_state_d[i] = RptIdle;
          end else if (rpt_cnt_q[i] == CNT_W'(REPEAT_CYCLES - 1)) begin
            step[i]      = 1'b1;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        default: rpt_state_d[i] = RptIdle;
      endcase
    end
  end

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] vol_q, vol_d;
  logic               muted_q, muted_d;
  logic               changed_q, changed_d;

  // Mute wins over a coincident step; opposing steps cancel; a step while
  // muted only unmutes.
  always_comb begin
    level_d = level_q;
    muted_d = muted_q;
    if (mute_press && mute_level) begin
      muted_d = ~muted_q;
    end else if (step[0] ^ step[1]) begin
      if (muted_q) muted_d = 1'b0;
      else         level_d = sat_step(level_q, step[0]);
    end
    vol_d     = muted_d ? '0 : level_d;
    changed_d = (vol_d != vol_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rpt_state_q[i] <= RptIdle;
        rpt_cnt_q[i]   <= '0;
      end
      level_q   <= RST_LEVEL;
      vol_q     <= RST_LEVEL;
      muted_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_cnt_q[i]   <= rpt_cnt_d[i];
      end
      level_q   <= level_d;
      vol_q     <= vol_d;
      muted_q   <= muted_d;
      changed_q <= changed_d;
    end
  end

  assign volume_level  = vol_q;
  assign muted         = muted_q;
  assign level_changed = changed_q;

endmodule

// File: tb/tb_volume_stepper.sv
// Bench for volume_stepper: table-driven short presses plus hand sequences for
// hold/repeat, glitches and reset mid-repeat; level_changed pulses go through a scoreboard.
module tb_volume_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_mute;
  logic [3:0] volume_level;
  logic       muted, level_changed;

  int checks = 0;
  int errors = 0;

  volume_stepper #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (5),
    .DEFAULT_LEVEL   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_mute      (btn_mute),
    .volume_level  (volume_level),
    .muted         (muted),
    .level_changed (level_changed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vol;
    logic       muted;
  } exp_t;

  exp_t exp_q[$];

  typedef struct packed {
    logic       up;
    logic       down;
    logic       mute;
    logic [3:0] vol;
    logic       muted;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int vol, input logic m);
    exp_t e;
    e.vol   = 4'(vol);
    e.muted = m;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic u, input logic d, input logic m, input int hold,
                       input int gap);
    btn_up   = u;
    btn_down = d;
    btn_mute = m;
    tick(hold);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_mute = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    tick(1);
    check({name, "_rst_vol"}, int'(volume_level), 8);
    check({name, "_rst_muted"}, int'(muted), 0);
    check({name, "_rst_changed"}, int'(level_changed), 0);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    check({name, "_sb_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every level_changed pulse must match the next expected value.
  always @(negedge clk) begin
    if (!reset && level_changed) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_pulse: got vol %0d muted %0d, expected no pulse",
                 volume_level, muted);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_vol", int'(volume_level), int'(e.vol));
        check("sb_muted", int'(muted), int'(e.muted));
      end
    end
  end

  initial begin
    int prev_vol;

    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_mute = 1'b0;
    reset    = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single short up press with exact latency.
    do_reset("t1");
    push(9, 1'b0);
    btn_up = 1'b1;
    tick(6);
    check("t1_before_edge", int'(volume_level), 8);
    tick(1);
    check("t1_at_edge", int'(volume_level), 9);
    check("t1_pulse", int'(level_changed), 1);
    tick(3);
    btn_up = 1'b0;
    tick(40);
    check("t1_final", int'(volume_level), 9);
    drain("t1");

    // Glitches shorter than the debounce window.
    do_reset("t2");
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, 3, 3);
    tick(20);
    check("t2_vol", int'(volume_level), 8);
    drain("t2");

    // Hold up: first step, hold delay, repeat, saturation at 15.
    do_reset("t3");
    for (int v = 9; v <= 15; v++) push(v, 1'b0);
    btn_up = 1'b1;
    tick(26);
    check("t3_hold_wait", int'(volume_level), 9);
    tick(1);
    check("t3_first_repeat", int'(volume_level), 10);
    tick(5);
    check("t3_second_repeat", int'(volume_level), 11);
    tick(28);
    btn_up = 1'b0;
    tick(15);
    check("t3_saturated", int'(volume_level), 15);
    drain("t3");
    push(14, 1'b0);
    press(1'b0, 1'b1, 1'b0, 10, 30);
    check("t3_idle_after_release", int'(volume_level), 14);
    drain("t3b");

    // Table of short presses: mute memory, unmute-consumes-step, cancellation, mute priority.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd9,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd10, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd11, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd12, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd12, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd11, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd11, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd11, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd11, 1'b0};
    do_reset("t4");
    prev_vol = 8;
    for (int i = 0; i < 12; i++) begin
      if (int'(vecs[i].vol) != prev_vol) push(int'(vecs[i].vol), vecs[i].muted);
      prev_vol = int'(vecs[i].vol);
      press(vecs[i].up, vecs[i].down, vecs[i].mute, 10, 14);
      check($sformatf("t4_vec%0d_vol", i), int'(volume_level), int'(vecs[i].vol));
      check($sformatf("t4_vec%0d_muted", i), int'(muted), int'(vecs[i].muted));
    end
    drain("t4");

    // Down to 2, hold down to 0, then mute/unmute at 0 without pulses.
    do_reset("t5");
    for (int v = 7; v >= 2; v--) begin
      push(v, 1'b0);
      press(1'b0, 1'b1, 1'b0, 10, 14);
    end
    check("t5_at_two", int'(volume_level), 2);
    push(1, 1'b0);
    push(0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 60, 15);
    check("t5_floor", int'(volume_level), 0);
    press(1'b0, 1'b0, 1'b1, 10, 14);
    check("t5_mute_at_zero", int'(muted), 1);
    press(1'b0, 1'b0, 1'b1, 10, 14);
    check("t5_unmute_at_zero", int'(muted), 0);
    check("t5_vol_zero", int'(volume_level), 0);
    drain("t5");

    // Reset during REPEAT at 13, button still held across reset release.
    do_reset("t6");
    for (int v = 9; v <= 13; v++) push(v, 1'b0);
    btn_up = 1'b1;
    tick(44);
    check("t6_pre_reset", int'(volume_level), 13);
    drain("t6a");
    reset = 1'b1;
    tick(1);
    check("t6_rst_vol", int'(volume_level), 8);
    check("t6_rst_muted", int'(muted), 0);
    check("t6_rst_changed", int'(level_changed), 0);
    reset = 1'b0;
    push(9, 1'b0);
    tick(6);
    check("t6_redebounce_wait", int'(volume_level), 8);
    tick(1);
    check("t6_new_step", int'(volume_level), 9);
    tick(3);
    btn_up = 1'b0;
    tick(30);
    check("t6_final", int'(volume_level), 9);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
